// File: rtl/stopwatch_counter_chain.sv
// Cascaded multi-digit stopwatch / countdown counter.
// Run/pause, preset load, lap hold, wrap and done flags.
module stopwatch_counter_chain #(
  parameter int DIGITS = 4,
  parameter int W = 4,
  parameter logic [DIGITS*W-1:0] MAX_PATTERN = 16'h5959
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                load,
  input  logic [DIGITS*W-1:0] load_value,
  input  logic                dir,
  input  logic                lap,
  output logic [DIGITS*W-1:0] count,
  output logic [DIGITS*W-1:0] display,
  output logic                running,
  output logic                lap_held,
  output logic                wrap,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic [DIGITS*W-1:0] count_q, count_d;
  logic [DIGITS*W-1:0] lap_q, lap_d;
  logic                lap_held_q, lap_held_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;

  logic [DIGITS*W-1:0] up_nxt, dn_nxt, ld_sat;
  logic [W-1:0]        dig, mx, ldd;
  logic                up_c, dn_b;
  logic                all_max, all_zero;

  // Ripple carry/borrow chain and saturated preset.
  always_comb begin
    up_nxt = count_q;
    dn_nxt = count_q;
    ld_sat = load_value;
    up_c = 1'b1;
    dn_b = 1'b1;
    dig = '0;
    mx = '0;
    ldd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[i*W +: W];
      mx  = MAX_PATTERN[i*W +: W];
      ldd = load_value[i*W +: W];
      if (up_c)
        up_nxt[i*W +: W] = (dig >= mx) ? '0 : dig + W'(1);
      if (dn_b)
        dn_nxt[i*W +: W] = (dig == '0) ? mx : dig - W'(1);
      ld_sat[i*W +: W] = (ldd > mx) ? mx : ldd;
      up_c = up_c && (dig >= mx);
      dn_b = dn_b && (dig == '0);
    end
    all_max  = up_c;
    all_zero = dn_b;
  end

  // Control priority: clear > load > start_stop > tick; lap independent.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    count_d    = count_q;
    lap_d      = lap_q;
    lap_held_d = lap_held_q;
    wrap_d     = 1'b0;
    done_d     = done_q;
    if (clear) begin
      count_d = '0;
      done_d  = 1'b0;
      state_d = S_IDLE;
    end else if (load && state_q != S_RUN) begin
      count_d = ld_sat;
      done_d  = 1'b0;
      state_d = S_IDLE;
    end else begin
      if (start_stop) begin
        unique case (state_q)
          S_IDLE, S_PAUSE: begin
            dir_d = dir;
            if (dir && count_q == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
          S_RUN:   state_d = S_PAUSE;
          default: state_d = state_q;
        endcase
      end
      if (tick && state_q == S_RUN) begin
        if (!dir_q) begin
          count_d = up_nxt;
          wrap_d  = all_max;
        end else if (!all_zero) begin
          count_d = dn_nxt;
          if (dn_nxt == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
    end
    if (lap) begin
      if (lap_held_q) begin
        lap_held_d = 1'b0;
      end else begin
        lap_held_d = 1'b1;
        lap_d      = count_d;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b0;
      count_q    <= '0;
      lap_q      <= '0;
      lap_held_q <= 1'b0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      lap_q      <= lap_d;
      lap_held_q <= lap_held_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
    end
  end

  assign count    = count_q;
  assign display  = lap_held_q ? lap_q : count_q;
  assign running  = (state_q == S_RUN);
  assign lap_held = lap_held_q;
  assign wrap     = wrap_q;
  assign done     = done_q;

endmodule

// File: tb/tb_stopwatch_counter_chain.sv
// Scoreboard bench for stopwatch_counter_chain.
// Mixed-radix integer model vs DUT outputs.
module tb_stopwatch_counter_chain;

  localparam int DIGITS = 4;
  localparam int W = 4;
  localparam logic [15:0] MAXP = 16'h5959;

  localparam int ST_IDLE = 0;
  localparam int ST_RUN = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE = 3;

  logic clk = 1'b0;
  logic rst;
  logic tick, start_stop, clear, load, dir, lap;
  logic [15:0] load_value;
  logic [15:0] count, display;
  logic running, lap_held, wrap, done;

  typedef struct packed {
    logic [15:0] cnt;
    logic [15:0] disp;
    logic        run;
    logic        held;
    logic        wrp;
    logic        dn;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int m_st, m_val, m_lapv;
  bit m_dir, m_held, m_done, m_wrap;

  stopwatch_counter_chain #(
    .DIGITS(DIGITS),
    .W(W),
    .MAX_PATTERN(MAXP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .start_stop(start_stop),
    .clear(clear),
    .load(load),
    .load_value(load_value),
    .dir(dir),
    .lap(lap),
    .count(count),
    .display(display),
    .running(running),
    .lap_held(lap_held),
    .wrap(wrap),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic int radix(int i);
    logic [15:0] mp;
    mp = MAXP;
    return int'(mp[i*4 +: 4]) + 1;
  endfunction

  function automatic int total();
    int t;
    t = 1;
    for (int i = 0; i < DIGITS; i++) t = t * radix(i);
    return t;
  endfunction

  function automatic int to_int(logic [15:0] p);
    int v, wgt;
    v = 0;
    wgt = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v = v + int'(p[i*4 +: 4]) * wgt;
      wgt = wgt * radix(i);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_packed(int v);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < DIGITS; i++) begin
      p[i*4 +: 4] = 4'(v % radix(i));
      v = v / radix(i);
    end
    return p;
  endfunction

  function automatic logic [15:0] sat(logic [15:0] p);
    for (int i = 0; i < DIGITS; i++)
      if (int'(p[i*4 +: 4]) > radix(i) - 1)
        p[i*4 +: 4] = 4'(radix(i) - 1);
    return p;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.cnt  = to_packed(m_val);
    o.disp = m_held ? to_packed(m_lapv) : o.cnt;
    o.run  = (m_st == ST_RUN);
    o.held = m_held;
    o.wrp  = m_wrap;
    o.dn   = m_done;
    return o;
  endfunction

  task automatic model_reset();
    m_st = ST_IDLE;
    m_val = 0;
    m_lapv = 0;
    m_dir = 0;
    m_held = 0;
    m_done = 0;
    m_wrap = 0;
  endtask

  task automatic model_step(bit clr, bit ld, logic [15:0] lv,
                            bit ss, bit tk, bit d, bit lp);
    int s;
    s = m_st;
    m_wrap = 0;
    if (clr) begin
      m_val = 0;
      m_done = 0;
      m_st = ST_IDLE;
    end else if (ld && s != ST_RUN) begin
      m_val = to_int(sat(lv));
      m_done = 0;
      m_st = ST_IDLE;
    end else begin
      if (ss) begin
        if (s == ST_IDLE || s == ST_PAUSE) begin
          m_dir = d;
          if (d && m_val == 0) begin
            m_st = ST_DONE;
            m_done = 1;
          end else begin
            m_st = ST_RUN;
          end
        end else if (s == ST_RUN) begin
          m_st = ST_PAUSE;
        end
      end
      if (tk && s == ST_RUN) begin
        if (!m_dir) begin
          m_val = (m_val + 1) % total();
          m_wrap = (m_val == 0);
        end else if (m_val != 0) begin
          m_val = m_val - 1;
          if (m_val == 0) begin
            m_st = ST_DONE;
            m_done = 1;
          end
        end
      end
    end
    if (lp) begin
      if (m_held) begin
        m_held = 0;
      end else begin
        m_held = 1;
        m_lapv = m_val;
      end
    end
  endtask

  task automatic step(bit clr, bit ld, logic [15:0] lv,
                      bit ss, bit tk, bit d, bit lp);
    @(negedge clk);
    clear = clr;
    load = ld;
    load_value = lv;
    start_stop = ss;
    tick = tk;
    dir = d;
    lap = lp;
    model_step(clr, ld, lv, ss, tk, d, lp);
    exp_q.push_back(model_obs());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, ex);
    end
  endtask

  // Monitor: compare each registered update against the scoreboard.
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{count, display, running, lap_held, wrap, done};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb t=%0t got=%h expected=%h", $time, a, e);
      end
    end
  end

  initial begin
    rst = 1'b1;
    tick = 0; start_stop = 0; clear = 0; load = 0;
    dir = 0; lap = 0; load_value = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_flags", {28'h0, running, lap_held, wrap, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 61 ticks from zero
    step(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 61; i++) step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("up61_count", 32'(count), 32'h0101);
    chk("up61_run", 32'(running), 32'h1);

    // full rollover
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 16'h5958, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("roll_5959", 32'(count), 32'h5959);
    step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("roll_zero", 32'(count), 32'h0);
    chk("roll_wrap", 32'(wrap), 32'h1);
    step(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("wrap_pulse", 32'(wrap), 32'h0);
    step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("roll_0001", 32'(count), 32'h0001);

    // countdown to done
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 16'h0002, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("dn_0001", 32'(count), 32'h0001);
    step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("dn_zero", 32'(count), 32'h0);
    chk("dn_done", {running, done}, 32'h1);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("done_hold", {count, 14'h0, running, done}, 32'h1);
    step(1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("clr_done", {running, done}, 32'h0);

    // load saturation and load ignored in RUN
    step(0, 1, 16'hFFA7, 0, 0, 0, 0);
    settle();
    chk("ld_sat", 32'(count), 32'h5957);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 16'h1234, 0, 0, 0, 0);
    settle();
    chk("ld_in_run", 32'(count), 32'h5957);

    // lap hold
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 16'h0010, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("lap_disp", 32'(display), 32'h0010);
    chk("lap_count", 32'(count), 32'h0015);
    step(0, 0, 0, 0, 0, 0, 1);
    settle();
    chk("lap_release", {display, 15'h0, lap_held}, {16'h0015, 16'h0});

    // clear beats start_stop and tick
    step(1, 0, 0, 1, 1, 0, 0);
    settle();
    chk("clr_prio", {count, 15'h0, running}, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("idle_tick", 32'(count), 32'h0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(63) == 0, $urandom_range(31) == 0,
           16'($urandom), $urandom_range(15) == 0,
           $urandom_range(1) == 1, $urandom_range(1) == 1,
           $urandom_range(19) == 0);
    end

    // async reset mid-run
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_count", {count, display}, 32'h0);
    chk("arst_flags", {28'h0, running, lap_held, wrap, done}, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick = 0; start_stop = 0; clear = 0; load = 0; lap = 0;
    step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("post_rst_tick", 32'(count), 32'h0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    settle();
    chk("post_rst_run", 32'(count), 32'h0001);
    step(0, 0, 0, 0, 0, 0, 0);
    settle();

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
